// File: rtl/line_rd_serializer.sv
// line_rd_serializer: takes a whole cache line in one cycle and streams it out
// as BEATS words of WORD_W bits, starting at start_word and wrapping
// (critical-word-first).
//
// Handshake semantics (both ports): a transfer happens on a posedge where
// valid && ready. Once word_valid rises it stays high, with word_out,
// word_idx and word_last stable, until that word is accepted. word_valid
// never drops mid-line except on reset. load_ready is 1 in IDLE. In SEND it
// is 1 only while the final beat is being accepted (word_last && word_ready).
// That path is combinational, so a new line can follow with no bubble.
module line_rd_serializer #(
  parameter int LINE_W = 512,
  parameter int WORD_W = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [LINE_W-1:0]                line_in,
  input  logic [$clog2(LINE_W/WORD_W)-1:0] start_word,
  input  logic                             load_valid,
  output logic                             load_ready,
  output logic [WORD_W-1:0]                word_out,
  output logic [$clog2(LINE_W/WORD_W)-1:0] word_idx,
  output logic                             word_valid,
  input  logic                             word_ready,
  output logic                             word_last,
  output logic                             busy
);

  localparam int BEATS = LINE_W / WORD_W;
  localparam int IDX_W = $clog2(BEATS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  // state is kept as a plain named signal so checkers can bind to it.
  state_t state;
  state_t state_nxt;

  // The line buffer is not reset. word_out is gated by word_valid, so stale
  // contents are never visible.
  logic [BEATS-1:0][WORD_W-1:0] line_q;
  logic [IDX_W-1:0]             idx_q;
  logic [IDX_W-1:0]             cnt_q;
  logic                         load_fire;
  logic                         beat_fire;

  // Output decode, handshake qualifiers and next-state selection.
  always_comb begin
    state_nxt  = state;
    word_valid = (state == SEND);
    busy       = (state == SEND);
    word_last  = (state == SEND) && (cnt_q == LAST);
    word_out   = (state == SEND) ? line_q[idx_q] : '0;
    word_idx   = (state == SEND) ? idx_q : '0;
    load_ready = (state == IDLE) || (word_last && word_ready);
    load_fire  = load_valid && load_ready;
    beat_fire  = word_valid && word_ready;
    case (state)
      IDLE: if (load_fire) state_nxt = SEND;
      SEND: if (beat_fire && word_last && !load_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register. Reset takes effect asynchronously, so word_valid drops
  // at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Word index and beat counter. A load takes priority, because on the final
  // beat the next line's start index replaces the wrap increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else if (load_fire) begin
      idx_q <= start_word;
      cnt_q <= '0;
    end else if (beat_fire) begin
      idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Line capture happens only on the load handshake. Later changes to
  // line_in do not disturb the line being drained.
  always_ff @(posedge clk) begin
    if (load_fire && !reset) line_q <= line_in;
  end

endmodule
